fht_input_loader: RTL and testbench
===================================

# fht_input_loader

Front-end stage of the FHT core, directly upstream of `fht_control`. It accepts one frame of N = 4·2^A_BIT samples over a valid/ready stream and scatters them into the four data RAM banks in bit-reversed order. After the last write it pulses `fht_control`'s start input, then holds off new input until the transform completes (`RDY` falls, then rises).

## Interface

Parameters:
- A_BIT, 8, per-bank address width; bank size 2^A_BIT, frame size N = 2^(A_BIT+2)
- D_BIT, 16, sample width

Ports (one clock; reset is synchronous and active-high):
- iCLK  in  1  system clock, all logic on rising edge
- iRESET  in  1  synchronous, active-high reset
- iDATA  in  D_BIT  input sample
- iVALID  in  1  iDATA valid
- oREADY  out  1  loader accepts a sample this cycle
- oADDR_WR  out  A_BIT  RAM write address, common to all banks
- oDATA  out  D_BIT  RAM write data
- oWE  out  4  one-hot bank write enable, bit k = bank k
- oSTART  out  1  one-cycle start pulse to fht_control iSTART
- iRDY  in  1  fht_control oRDY: 1 = idle/done, 0 = transform running
- oBUSY  out  1  frame loaded, transform pending or running

## Operation

- Sample counter n, width A_BIT+2, counts accepted samples 0..N-1.
- Reversed index r = bit-reverse of n over A_BIT+2 bits. Bank = r[1:0], address = r[A_BIT+1:2].
- States:
  - LOAD: oREADY=1. On iVALID&oREADY, register the write (oDATA=iDATA, oADDR_WR, oWE=onehot(bank)) and increment n. Accepting n=N-1 moves to FLUSH; n wraps to 0.
  - FLUSH: one cycle; the last write is on the RAM port. oREADY=0. Go to START.
  - START: oSTART=1 for exactly one cycle. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for iRDY=0. Go to WAIT_DONE.
  - WAIT_DONE: wait for iRDY=1. Go to LOAD.
- oBUSY=1 in FLUSH, START, WAIT_BUSY and WAIT_DONE; 0 in LOAD.
- oWE is 0 in every cycle that does not carry a registered write, including all non-LOAD cycles except the FLUSH write cycle.
- No handshake applies to writes; RAM ports are always writable.
- iVALID while oREADY=0 is ignored; no sample is consumed.
- Reset at any point, mid-frame included: state goes to LOAD, n=0, and partial frame data is discarded (RAM contents undefined). A transform already in progress in fht_control is not aborted by this block.

## Timing

- Reset values: oREADY=0 in the reset cycle and 1 in the first cycle after reset. oADDR_WR=0, oDATA=0, oWE=0, oSTART=0, oBUSY=0.
- Write latency: a sample accepted at edge t appears on oDATA/oADDR_WR/oWE during cycle t..t+1, i.e. registered, 1 cycle.
- Last sample accepted at edge t: the last write is visible in the following cycle (FLUSH). oSTART is high in the next cycle, 2 cycles after acceptance, so the RAM write is committed before start is sampled.
- Full-rate input sustains 1 sample/cycle, giving N cycles per frame load.
- iRDY is already 0 on entering WAIT_BUSY: the state advances on the next edge.
- iRDY never falls: the block stays in WAIT_BUSY indefinitely. No timeout.
- Minimum gap from oSTART to oREADY=1 is 3 cycles (iRDY pulse low for 1 cycle).

## Test plan

- Reset then A_BIT=2 (N=16), stream samples 0..15 at full rate. Required writes: n=0 → bank0 addr0; n=1 → bank0 addr2; n=2 → bank0 addr1; n=4 → bank2 addr0; n=5 → bank2 addr2; n=15 → bank3 addr3. oWE is one-hot on every write, and exactly 16 writes occur.
- Same frame: the last sample is accepted at edge t. Required: oWE≠0 in cycle t+1, oSTART=1 only in cycle t+2, and oREADY=0 from t+1 until iRDY returns high.
- iVALID toggled randomly 50%. Required: the same bank/address mapping holds, and no write occurs in cycles where the handshake did not complete.
- Behavioural fht_control model drives iRDY low 5 cycles after oSTART, high after 100 cycles. Required: oBUSY=1 throughout, and oREADY=1 the cycle after iRDY rises. Then load a second frame and check the n counter restarted at 0 (first write bank0 addr0).
- Assert iRESET after 7 samples. Required: all outputs return to reset values next cycle, and the next accepted sample is written to bank0 addr0. No oSTART occurs until 16 new samples have been accepted.
- Hold iVALID=1 during WAIT_DONE. Required: no sample is consumed, and oWE stays 0.

Source files
------------

// File: rtl/fht_input_loader.sv
// Streams one N-sample frame into four RAM banks in bit-reversed order, then starts fht_control.
// Write latency 1 cycle; oREADY drops from the last accept until the transform reports done.
module fht_input_loader #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic [D_BIT-1:0] iDATA,
  input  logic             iVALID,
  output logic             oREADY,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [D_BIT-1:0] oDATA,
  output logic [3:0]       oWE,
  output logic             oSTART,
  input  logic             iRDY,
  output logic             oBUSY
);

  localparam int C_BIT = A_BIT + 2;

  typedef enum logic [2:0] {
    S_LOAD,
    S_FLUSH,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t           state;
  logic [C_BIT-1:0] cnt;
  logic [C_BIT-1:0] rev;
  logic             accept;

  always_comb begin
    rev = '0;
    for (int i = 0; i < C_BIT; i++) begin
      rev[i] = cnt[C_BIT-1-i];
    end
  end

  // Gated by reset so the reset cycle itself never advertises ready.
  assign oREADY = (state == S_LOAD) && !iRESET;
  assign accept = iVALID && oREADY;

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state    <= S_LOAD;
      cnt      <= '0;
      oADDR_WR <= '0;
      oDATA    <= '0;
      oWE      <= '0;
      oSTART   <= 1'b0;
      oBUSY    <= 1'b0;
    end else begin
      oWE    <= '0;
      oSTART <= 1'b0;
      case (state)
        S_LOAD: begin
          if (accept) begin
            oDATA    <= iDATA;
            oADDR_WR <= rev[C_BIT-1:2];
            oWE      <= 4'b0001 << rev[1:0];
            cnt      <= cnt + C_BIT'(1);
            if (cnt == '1) begin
              state <= S_FLUSH;
              oBUSY <= 1'b1;
            end
          end
        end
        // Last write sits on the RAM port this cycle; start follows once it has landed.
        S_FLUSH: begin
          oSTART <= 1'b1;
          state  <= S_START;
        end
        S_START: begin
          state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!iRDY) begin
            state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (iRDY) begin
            state <= S_LOAD;
            oBUSY <= 1'b0;
          end
        end
        default: begin
          state <= S_LOAD;
          oBUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fht_input_loader.sv
// Scoreboard bench for fht_input_loader at A_BIT=2 (N=16) with a behavioural fht_control.
module tb_fht_input_loader;

  localparam int A_BIT = 2;
  localparam int D_BIT = 16;

  logic             iCLK;
  logic             iRESET;
  logic [D_BIT-1:0] iDATA;
  logic             iVALID;
  logic             oREADY;
  logic [A_BIT-1:0] oADDR_WR;
  logic [D_BIT-1:0] oDATA;
  logic [3:0]       oWE;
  logic             oSTART;
  logic             iRDY;
  logic             oBUSY;

  fht_input_loader #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
    .iCLK    (iCLK),
    .iRESET  (iRESET),
    .iDATA   (iDATA),
    .iVALID  (iVALID),
    .oREADY  (oREADY),
    .oADDR_WR(oADDR_WR),
    .oDATA   (oDATA),
    .oWE     (oWE),
    .oSTART  (oSTART),
    .iRDY    (iRDY),
    .oBUSY   (oBUSY)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [3:0]       n;
    logic [D_BIT-1:0] dat;
  } sb_item_t;

  sb_item_t   sb_q[$];
  sb_item_t   mon_e;
  logic [3:0] mon_r;
  logic [3:0] model_n;
  logic [3:0] obs_we[16];
  logic [1:0] obs_addr[16];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int acc_cyc = 0;
  int first_acc = 0;
  int rdy_delay = 5;
  int rdy_len = 100;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  function automatic logic [3:0] brev(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  always @(posedge iCLK) cyc++;

  // Write monitor: every enabled write must match the oldest accepted sample.
  always @(negedge iCLK) begin
    if (oSTART) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (oWE != 4'd0) begin
      wr_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_write", {28'd0, oWE}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        mon_r = brev(mon_e.n);
        chk("we", {28'd0, oWE}, {28'd0, 4'b0001 << mon_r[1:0]});
        chk("addr", {30'd0, oADDR_WR}, {30'd0, mon_r[3:2]});
        chk("data", {16'd0, oDATA}, {16'd0, mon_e.dat});
        obs_we[mon_e.n]   = oWE;
        obs_addr[mon_e.n] = oADDR_WR;
      end
    end
  end

  // Behavioural fht_control: busy rdy_delay edges after start, for rdy_len edges.
  always begin
    @(negedge iCLK);
    if (oSTART) begin
      repeat (rdy_delay) @(posedge iCLK);
      #1 iRDY = 1'b0;
      repeat (rdy_len) @(posedge iCLK);
      #1 iRDY = 1'b1;
      rise_cyc = cyc;
    end
  end

  task automatic clear_obs();
    for (int i = 0; i < 16; i++) begin
      obs_we[i]   = 4'd0;
      obs_addr[i] = 2'd0;
    end
    wr_cnt = 0;
  endtask

  task automatic drive(input int nsamp, input int pct);
    int sent;
    int guard;
    sent  = 0;
    guard = 0;
    while (sent < nsamp && guard < 1000) begin
      @(posedge iCLK);
      #1;
      iVALID = ($urandom_range(99) < pct);
      iDATA  = D_BIT'($urandom);
      if (iVALID && oREADY) begin
        sb_q.push_back('{n: model_n, dat: iDATA});
        if (sent == 0) first_acc = cyc + 1;
        acc_cyc = cyc + 1;
        model_n++;
        sent++;
      end
      guard++;
    end
    @(posedge iCLK);
    #1;
    iVALID = 1'b0;
    if (sent != nsamp) chk("drive_timeout", sent, nsamp);
  endtask

  task automatic wait_ready(input bit hold_valid, output int rdy_cyc);
    int guard;
    int busy_bad;
    int we_seen;
    int vh;
    bit ok;
    guard    = 0;
    busy_bad = 0;
    we_seen  = 0;
    vh       = 0;
    ok       = 1'b0;
    rdy_cyc  = 0;
    while (guard < 400) begin
      @(negedge iCLK);
      if (oREADY) begin
        ok      = 1'b1;
        rdy_cyc = cyc;
        break;
      end
      if (!oBUSY) busy_bad++;
      if (hold_valid && oWE != 4'd0) we_seen++;
      iVALID = hold_valid && !iRDY;
      if (iVALID) vh++;
      guard++;
    end
    iVALID = 1'b0;
    chk("ready_returned", ok, 1);
    chk("busy_while_waiting", busy_bad, 0);
    if (hold_valid) begin
      chk("valid_held_in_wait", vh > 0, 1);
      chk("we_while_waiting", we_seen, 0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"}, {28'd0, oWE}, 32'd0);
    chk({tag, "_start"}, oSTART, 0);
    chk({tag, "_busy"}, oBUSY, 0);
    chk({tag, "_addr"}, {30'd0, oADDR_WR}, 32'd0);
    chk({tag, "_data"}, {16'd0, oDATA}, 32'd0);
  endtask

  int rc;
  int sc;
  int tn[6] = '{0, 1, 2, 4, 5, 15};
  int tw[6] = '{1, 1, 1, 4, 4, 8};
  int ta[6] = '{0, 2, 1, 0, 2, 3};

  initial begin
    iRESET  = 1'b1;
    iVALID  = 1'b0;
    iDATA   = '0;
    iRDY    = 1'b1;
    model_n = 4'd0;
    clear_obs();

    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    chk("rst_ready", oREADY, 0);
    chk_reset_outputs("rst");
    @(posedge iCLK);
    #1 iRESET = 1'b0;
    @(negedge iCLK);
    chk("post_rst_ready", oREADY, 1);

    // Frame 1: full rate, slow transform, iVALID held high while it runs.
    rdy_delay = 5;
    rdy_len   = 100;
    clear_obs();
    drive(16, 100);
    chk("full_rate_span", acc_cyc - first_acc, 15);
    @(negedge iCLK);
    chk("flush_we", oWE != 4'd0, 1);
    chk("flush_start", oSTART, 0);
    chk("flush_ready", oREADY, 0);
    chk("flush_busy", oBUSY, 1);
    @(negedge iCLK);
    chk("start_pulse", oSTART, 1);
    chk("start_we", {28'd0, oWE}, 32'd0);
    chk("start_ready", oREADY, 0);
    chk("start_busy", oBUSY, 1);
    chk("start_cycle", cyc - acc_cyc, 1);
    wait_ready(1'b1, rc);
    chk("ready_after_rise", rc - rise_cyc, 1);
    chk("f1_start_count", start_cnt, 1);
    chk("f1_writes", wr_cnt, 16);
    chk("f1_sb_empty", sb_q.size(), 0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("f1_map_we_n%0d", tn[i]), {28'd0, obs_we[tn[i]]}, tw[i]);
      chk($sformatf("f1_map_addr_n%0d", tn[i]), {30'd0, obs_addr[tn[i]]}, ta[i]);
    end

    // Frame 2: random valid, shortest transform handshake.
    rdy_delay = 1;
    rdy_len   = 1;
    clear_obs();
    drive(16, 50);
    wait_ready(1'b0, rc);
    chk("min_gap", rc - start_cyc, 3);
    chk("f2_first_we", {28'd0, obs_we[0]}, 1);
    chk("f2_first_addr", {30'd0, obs_addr[0]}, 0);
    chk("f2_n4_we", {28'd0, obs_we[4]}, 4);
    chk("f2_writes", wr_cnt, 16);
    chk("f2_start_count", start_cnt, 2);

    // Frame 3: reset after 7 samples, then a complete fresh frame.
    drive(7, 100);
    iRESET = 1'b1;
    @(negedge iCLK);
    chk("midrst_ready", oREADY, 0);
    @(posedge iCLK);
    #1 iRESET = 1'b0;
    model_n = 4'd0;
    @(negedge iCLK);
    chk("midrst_ready_after", oREADY, 1);
    chk_reset_outputs("midrst");
    chk("midrst_sb_empty", sb_q.size(), 0);
    sc = start_cnt;
    clear_obs();
    drive(15, 70);
    repeat (3) @(negedge iCLK);
    chk("no_start_at_15", start_cnt, sc);
    chk("ready_at_15", oREADY, 1);
    drive(1, 100);
    wait_ready(1'b0, rc);
    chk("f3_start_count", start_cnt, sc + 1);
    chk("f3_first_we", {28'd0, obs_we[0]}, 1);
    chk("f3_first_addr", {30'd0, obs_addr[0]}, 0);
    chk("f3_writes", wr_cnt, 16);
    chk("f3_sb_empty", sb_q.size(), 0);

    repeat (2) @(negedge iCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
